// File: rtl/multi_reg_file_pkg.sv
// Shared definitions for the multi_reg_file slice: function-select codes and
// the read-select width helper.
package regfile_pkg;

  typedef enum logic [1:0] {
    FS_DEC  = 2'd0,
    FS_INC  = 2'd1,
    FS_LOAD = 2'd2,
    FS_CLR  = 2'd3
  } funsel_e;

  // Read index width; a single-bit select is kept even for tiny depths.
  function automatic int selw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/multi_reg_file_if.sv
// Datapath-side bundle of the register file: write controls, read selects,
// read data and sticky boundary flags.
interface multi_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = regfile_pkg::selw(DEPTH)
) ();
  logic [1:0]       FunSel;
  logic [DEPTH-1:0] RegSel;
  logic [WIDTH-1:0] I;
  logic [SELW-1:0]  OutASel;
  logic [SELW-1:0]  OutBSel;
  logic             FlagClr;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic [DEPTH-1:0] BndFlag;

  modport master (
    output FunSel, RegSel, I, OutASel, OutBSel, FlagClr,
    input  OutA, OutB, BndFlag
  );

  modport slave (
    input  FunSel, RegSel, I, OutASel, OutBSel, FlagClr,
    output OutA, OutB, BndFlag
  );
endinterface

// File: rtl/multi_reg_file_bnd_counter_reg.sv
// One counter-register with wrap or saturate boundary handling and a sticky
// boundary flag.
module bnd_counter_reg
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_en,
  input  logic [1:0]       i_fun,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flag_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_flag
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_flag;
  logic [WIDTH-1:0] w_nxt;
  logic             w_bnd;
  logic             w_at_max, w_at_min;

  assign w_at_max = &r_q;
  assign w_at_min = ~|r_q;

  // Boundary is judged on the pre-edge value; saturation simply holds it.
  always_comb begin
    w_nxt = r_q;
    w_bnd = 1'b0;
    case (funsel_e'(i_fun))
      FS_DEC: begin
        w_bnd = i_en & w_at_min;
        w_nxt = (w_at_min && SATURATE) ? r_q : r_q - ONE;
      end
      FS_INC: begin
        w_bnd = i_en & w_at_max;
        w_nxt = (w_at_max && SATURATE) ? r_q : r_q + ONE;
      end
      FS_LOAD: w_nxt = i_data;
      FS_CLR:  w_nxt = '0;
      default: w_nxt = r_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q    <= RESET_VAL;
      r_flag <= 1'b0;
    end else begin
      if (i_en) r_q <= w_nxt;
      if (w_bnd)           r_flag <= 1'b1;
      else if (i_flag_clr) r_flag <= 1'b0;
    end
  end

  assign o_q    = r_q;
  assign o_flag = r_flag;

endmodule

// File: rtl/multi_reg_file.sv
// DEPTH x WIDTH counter register file with two combinational read ports;
// out-of-range read indices return zero.
module multi_reg_file
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             CLK,
  input logic             RST_N,
  multi_reg_file_if.slave bus
);

  localparam int SELW = selw(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] w_q;
  logic [DEPTH-1:0]            w_flag;
  logic [WIDTH-1:0]            w_outa, w_outb;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    bnd_counter_reg #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE),
      .RESET_VAL(RESET_VAL)
    ) u_reg (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .i_en      (~bus.RegSel[g]),
      .i_fun     (bus.FunSel),
      .i_data    (bus.I),
      .i_flag_clr(bus.FlagClr),
      .o_q       (w_q[g]),
      .o_flag    (w_flag[g])
    );
  end

  // Compare-based mux so indices past DEPTH fall through to zero.
  always_comb begin
    w_outa = '0;
    w_outb = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.OutASel == SELW'(k)) w_outa = w_q[k];
      if (bus.OutBSel == SELW'(k)) w_outb = w_q[k];
    end
  end

  assign bus.OutA    = w_outa;
  assign bus.OutB    = w_outb;
  assign bus.BndFlag = w_flag;

endmodule
